reg_writeback_queue: RTL and testbench
======================================

// Module: reg_writeback_queue
// PURPOSE
//  Writer end of the 64-bit, 32-entry register file write port (RegWrite/RD/WriteData).
//  Accepts writeback requests from the ALU and load (mem) paths via valid/ready and buffers
//  them in an in-order FIFO. Retires one write per cycle into the register file.
//  Provides a pending-write lookup so decode can stall on RAW hazards.
// PARAMETERS
//  XLEN   64  data width of register file entries
//  DEPTH  4   FIFO entries; power of 2, >=2
// PORTS
//  clk           in   1            clock; all state updates on rising edge
//  reset         in   1            synchronous, active-high
//  mem_valid     in   1            load writeback request
//  mem_rd        in   5            load destination register
//  mem_data      in   XLEN         load result
//  mem_ready     out  1            load request accepted when valid&ready at clk edge
//  alu_valid     in   1            ALU writeback request
//  alu_rd        in   5            ALU destination register
//  alu_data      in   XLEN         ALU result
//  alu_ready     out  1            ALU request accepted when valid&ready at clk edge
//  rf_regwrite   out  1            register file RegWrite
//  rf_rd         out  5            register file RD
//  rf_wdata      out  XLEN         register file WriteData
//  chk_rs        in   5            register index queried by decode
//  chk_pending   out  1            1 = queued write to chk_rs not yet retired
//  count         out  clog2(DEPTH+1)  entries held
//  full          out  1            count==DEPTH
// BEHAVIOUR
//  - Storage: circular FIFO of {rd,data}. wr_ptr/rd_ptr wrap modulo DEPTH.
//  - Retire: head drives rf_rd/rf_wdata combinationally. rf_regwrite = !empty & !reset.
//    Head pops at every edge where rf_regwrite=1, i.e. one register-file write per cycle.
//  - Latency: request accepted at edge T into an empty FIFO is presented during cycle T..T+1.
//    The register file captures it at edge T+1.
//  - Free slots: free = DEPTH - count + (count!=0). Counts the pop in the same cycle.
//  - Ready rules:
//    - mem_ready = (free>=1).
//    - alu_ready = mem_valid ? (free>=2) : (free>=1).
//    - Both ready signals are 0 while reset=1.
//  - Simultaneous accept: mem entry enqueued ahead of ALU entry. If both name the same rd,
//    ALU value is the final register contents.
//  - rd==0: handshake completes normally but the entry is discarded (not enqueued, no free
//    slot consumed). x0 is never written.
//  - count_next = count + pushes - pop. Push and pop in the same edge are legal at any count,
//    including full.
//  - chk_pending = (chk_rs!=0) & OR over occupied entries (head included) of entry.rd==chk_rs.
//    Purely combinational from current state; no bypass of same-cycle requests.
//  - Empty: rf_regwrite=0, rf_rd=0, rf_wdata=0 (forced, no stale head data).
//  - Reset (any cycle, including mid-drain):
//    - count=0, wr_ptr=rd_ptr=0; all queued entries discarded.
//    - rf_regwrite=0 in the reset cycle and the cycle after; no write reaches the register file.
//    - Outputs after reset: full=0, chk_pending=0, count=0, rf_rd=0, rf_wdata=0.
//    - Readies go to 1 once reset deasserts.
// TESTING
//  1. Single: alu_valid, rd=5, data=0xAA for 1 cycle
//     -> next cycle rf_regwrite=1 rf_rd=5 rf_wdata=0xAA; following cycle rf_regwrite=0, count=0.
//  2. Same cycle: mem{rd=3,0x11} + alu{rd=3,0x22}
//     -> cycle+1 writes 0x11, cycle+2 writes 0x22; chk_rs=3 pending for both cycles, then 0.
//  3. alu_valid rd=0 data=0xFF
//     -> alu_ready=1, count stays 0, rf_regwrite stays 0; chk_rs=0 -> chk_pending=0.
//  4. Both producers valid every cycle, DEPTH=4, unique rd/data
//     -> count 2,3,4; full=1; then alu_ready=0 while mem_valid=1.
//     -> Sustained 1 write/cycle; retire order equals accept order, no loss or duplication.
//  5. Queue 3 entries, assert reset 1 cycle mid-drain
//     -> rf_regwrite=0 during and after reset, count=0, none of the remaining entries written.
//  6. 10 back-to-back ALU writes rd=1..10, data=rd*0x100
//     -> pointer wrap exercised; 10 writes retire in order with matching data.

Source files
------------

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
// Writer end of the register-file write port. ALU and load writebacks are
// accepted through valid/ready and held in an in-order circular FIFO of
// {rd,data}. The head is retired into the register file at one write per
// cycle. A pending-write lookup lets decode stall on RAW hazards.
// Requests to x0 complete their handshake but are dropped without using a slot.
module reg_writeback_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    // load path
    input  logic                         mem_valid,
    input  logic [4:0]                   mem_rd,
    input  logic [XLEN-1:0]              mem_data,
    output logic                         mem_ready,
    // ALU path
    input  logic                         alu_valid,
    input  logic [4:0]                   alu_rd,
    input  logic [XLEN-1:0]              alu_data,
    output logic                         alu_ready,
    // register file write port
    output logic                         rf_regwrite,
    output logic [4:0]                   rf_rd,
    output logic [XLEN-1:0]              rf_wdata,
    // hazard lookup
    input  logic [4:0]                   chk_rs,
    output logic                         chk_pending,
    // occupancy
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [CNT_W:0]   FREE_DEPTH = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W:0]   FREE_ONE   = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]   FREE_TWO   = (CNT_W+1)'(2);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);

    // FIFO storage (data only, never reset)
    logic [4:0]       slot_rd   [DEPTH];
    logic [XLEN-1:0]  slot_data [DEPTH];

    // FIFO control state
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             empty;
    logic             pop;
    logic [CNT_W:0]   free;
    logic             mem_push;
    logic             alu_push;
    logic [1:0]       n_push;
    logic [PTR_W-1:0] alu_slot;
    logic [CNT_W-1:0] count_next;
    logic [DEPTH-1:0] hit;

    // Handshake, pop and occupancy arithmetic
    always_comb begin
        empty = (count == '0);
        // The head retires every cycle the queue holds something and reset is low.
        pop   = !empty && !reset;
        // A slot freed by this cycle's pop can be refilled at the same edge.
        free  = FREE_DEPTH - {1'b0, count} + {{CNT_W{1'b0}}, !empty};

        mem_ready = !reset && (free >= FREE_ONE);
        // The load path gets the slot first when both producers compete.
        alu_ready = !reset && (mem_valid ? (free >= FREE_TWO) : (free >= FREE_ONE));

        mem_push  = mem_valid && mem_ready && (mem_rd != 5'd0);
        alu_push  = alu_valid && alu_ready && (alu_rd != 5'd0);
        n_push    = {1'b0, mem_push} + {1'b0, alu_push};

        // ALU entry lands behind the load entry when both are pushed together.
        alu_slot  = mem_push ? (wr_ptr + PTR_W'(1)) : wr_ptr;

        count_next = count + CNT_W'(n_push) - CNT_W'(pop);
    end

    // Register-file port: head when retiring, zeros otherwise
    always_comb begin
        rf_regwrite = pop;
        rf_rd       = pop ? slot_rd[rd_ptr]   : 5'd0;
        rf_wdata    = pop ? slot_data[rd_ptr] : '0;
        full        = (count == CNT_FULL);
    end

    // A slot is occupied when its distance from the head is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PTR_W-1:0] off;
        assign off    = PTR_W'(i) - rd_ptr;
        assign hit[i] = ({1'b0, off} < count) && (slot_rd[i] == chk_rs);
    end

    // Hazard lookup over queued entries only; same-cycle requests are not seen
    always_comb begin
        chk_pending = (chk_rs != 5'd0) && (|hit);
    end

    // Write accepted entries into their slots
    always_ff @(posedge clk) begin
        if (mem_push) begin
            slot_rd[wr_ptr]   <= mem_rd;
            slot_data[wr_ptr] <= mem_data;
        end
        if (alu_push) begin
            slot_rd[alu_slot]   <= alu_rd;
            slot_data[alu_slot] <= alu_data;
        end
    end

    // Pointer and count update; reset discards every queued entry
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count_next;
        end
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue
// Directed stimulus for reg_writeback_queue with a queue-based reference
// model checked every cycle, plus literal expectations at key points.
module tb_reg_writeback_queue;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             mem_valid;
    logic [4:0]       mem_rd;
    logic [XLEN-1:0]  mem_data;
    logic             mem_ready;
    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             alu_ready;
    logic             rf_regwrite;
    logic [4:0]       rf_rd;
    logic [XLEN-1:0]  rf_wdata;
    logic [4:0]       chk_rs;
    logic             chk_pending;
    logic [2:0]       count;
    logic             full;

    reg_writeback_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .rf_regwrite (rf_regwrite),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata),
        .chk_rs      (chk_rs),
        .chk_pending (chk_pending),
        .count       (count),
        .full        (full)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit started     = 1'b0;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            q[$];          // model of queued writes, head at index 0
    logic [XLEN-1:0] rf_cap [32];   // register file as written by the DUT
    logic [4:0]      wlog[$];       // rd of every DUT write, in order
    int              x0_writes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_free();
        int sz;
        sz = q.size();
        return DEPTH - sz + ((sz != 0) ? 1 : 0);
    endfunction

    function automatic bit m_mem_ready();
        return !reset && (m_free() >= 1);
    endfunction

    function automatic bit m_alu_ready();
        return !reset && (mem_valid ? (m_free() >= 2) : (m_free() >= 1));
    endfunction

    function automatic bit m_pending();
        bit p;
        p = 1'b0;
        if (chk_rs != 5'd0)
            foreach (q[i]) if (q[i].rd == chk_rs) p = 1'b1;
        return p;
    endfunction

    // Reference model update and capture of DUT register-file writes
    always @(posedge clk) begin
        bit   ma, aa;
        ent_t e;
        if (reset) begin
            q.delete();
            started = 1'b1;
        end else if (started) begin
            ma = mem_valid && m_mem_ready();
            aa = alu_valid && m_alu_ready();
            if (q.size() > 0) void'(q.pop_front());
            if (ma && mem_rd != 5'd0) begin e = {mem_rd, mem_data}; q.push_back(e); end
            if (aa && alu_rd != 5'd0) begin e = {alu_rd, alu_data}; q.push_back(e); end
        end
        if (rf_regwrite === 1'b1) begin
            rf_cap[rf_rd] = rf_wdata;
            wlog.push_back(rf_rd);
            if (rf_rd == 5'd0) x0_writes++;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        int sz;
        bit ewe;
        if (started) begin
            sz  = q.size();
            ewe = (sz > 0) && !reset;
            chk("mem_ready",   mem_ready,   m_mem_ready());
            chk("alu_ready",   alu_ready,   m_alu_ready());
            chk("rf_regwrite", rf_regwrite, ewe);
            chk("count",       count,       sz);
            chk("full",        full,        sz == DEPTH);
            chk("chk_pending", chk_pending, m_pending());
            if (ewe) begin
                chk("rf_rd",    rf_rd,    q[0].rd);
                chk("rf_wdata", rf_wdata, q[0].data);
            end else if (sz == 0) begin
                chk("rf_rd_empty",    rf_rd,    0);
                chk("rf_wdata_empty", rf_wdata, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = '0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 12 && count != 3'd0; i++) tick();
        chk(name, count, 0);
    endtask

    int exp_cnt [6] = '{2, 3, 4, 4, 4, 4};

    initial begin
        foreach (rf_cap[i]) rf_cap[i] = '0;
        idle();
        chk_rs = 5'd0;
        reset  = 1'b1;
        tick(); tick();
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_regwrite",  rf_regwrite, 0);
        reset  = 1'b0;
        chk_rs = 5'd5;
        #1;
        chk("post_rst_count",   count, 0);
        chk("post_rst_full",    full, 0);
        chk("post_rst_pending", chk_pending, 0);
        chk("post_rst_rf_rd",   rf_rd, 0);
        chk("post_rst_wdata",   rf_wdata, 0);
        chk("post_rst_mready",  mem_ready, 1);
        chk("post_rst_aready",  alu_ready, 1);

        // Single ALU write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hAA;
        #1;
        chk("t1_no_bypass", chk_pending, 0);
        tick(); idle();
        chk("t1_we",      rf_regwrite, 1);
        chk("t1_rd",      rf_rd, 5);
        chk("t1_wdata",   rf_wdata, 64'hAA);
        chk("t1_pending", chk_pending, 1);
        tick();
        chk("t1_we_off",  rf_regwrite, 0);
        chk("t1_count",   count, 0);
        chk("t1_pend_off", chk_pending, 0);

        // Same-cycle mem + ALU to the same register
        chk_rs = 5'd3;
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'h11;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h22;
        tick(); idle();
        chk("t2_wdata0", rf_wdata, 64'h11);
        chk("t2_count0", count, 2);
        chk("t2_pend0",  chk_pending, 1);
        tick();
        chk("t2_wdata1", rf_wdata, 64'h22);
        chk("t2_pend1",  chk_pending, 1);
        tick();
        chk("t2_we_off", rf_regwrite, 0);
        chk("t2_pend2",  chk_pending, 0);
        chk("t2_x3",     rf_cap[3], 64'h22);

        // Write to x0 is handshaken and dropped
        chk_rs = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF;
        #1;
        chk("t3_ready", alu_ready, 1);
        tick(); idle();
        chk("t3_count",   count, 0);
        chk("t3_we",      rf_regwrite, 0);
        chk("t3_pending", chk_pending, 0);
        tick();
        chk("t3_we2",     rf_regwrite, 0);

        // Both producers every cycle: fill, saturate, sustain
        for (int k = 0; k < 6; k++) begin
            mem_valid = 1'b1; mem_rd = 5'(1 + 2*k); mem_data = 64'h1000 + 64'(1 + 2*k);
            alu_valid = 1'b1; alu_rd = 5'(2 + 2*k); alu_data = 64'h2000 + 64'(2 + 2*k);
            #1;
            if (k >= 3) begin
                chk("t4_alu_blocked", alu_ready, 0);
                chk("t4_mem_open",    mem_ready, 1);
            end
            tick();
            chk("t4_count", count, exp_cnt[k]);
            if (k >= 2) chk("t4_full", full, 1);
            if (k == 0) begin
                chk("t4_first_rd",    rf_rd, 1);
                chk("t4_first_wdata", rf_wdata, 64'h1001);
            end
        end
        idle();
        drain("t4_drain");

        // Reset mid-drain discards remaining entries
        mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 64'h2020;
        alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 64'h2121;
        tick();
        mem_rd = 5'd22; mem_data = 64'h2222;
        alu_rd = 5'd23; alu_data = 64'h2323;
        tick(); idle();
        chk("t5_count3", count, 3);
        chk("t5_head",   rf_rd, 21);
        reset = 1'b1;
        #1;
        chk("t5_we_rst",     rf_regwrite, 0);
        chk("t5_mready_rst", mem_ready, 0);
        chk("t5_aready_rst", alu_ready, 0);
        tick();
        reset  = 1'b0;
        chk_rs = 5'd22;
        #1;
        chk("t5_count",   count, 0);
        chk("t5_we_post", rf_regwrite, 0);
        chk("t5_full",    full, 0);
        chk("t5_pending", chk_pending, 0);
        chk("t5_rf_rd",   rf_rd, 0);
        chk("t5_wdata",   rf_wdata, 0);
        tick();
        chk("t5_we_after", rf_regwrite, 0);
        chk("t5_x20", rf_cap[20], 64'h2020);
        chk("t5_x21", rf_cap[21], 0);
        chk("t5_x22", rf_cap[22], 0);
        chk("t5_x23", rf_cap[23], 0);

        // Ten back-to-back ALU writes wrap the pointers
        wlog.delete();
        chk_rs = 5'd0;
        for (int i = 1; i <= 10; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 64'(i) * 64'h100;
            tick();
        end
        idle();
        drain("t6_drain");
        chk("t6_nwrites", wlog.size(), 10);
        for (int i = 0; i < 10 && i < wlog.size(); i++) begin
            chk("t6_order", wlog[i], i + 1);
            chk("t6_data",  rf_cap[i + 1], 64'(i + 1) * 64'h100);
        end
        chk("x0_never_written", x0_writes, 0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
